// File: rtl/alu_4_bit.sv
// Registered 4-bit ALU (ADD/SUB/AND/OR) with optional status flags (macro ALU_4BIT_FLAGS_EN).
// Latency: 1 core clock from an accepted in_valid to out_valid/f/flags.
// Backpressure: none; one operation accepted every cycle, in_valid=0 holds f and flags.
module alu_4_bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  output logic       out_valid,
  output logic [3:0] f,
  output logic       carry,
  output logic       zero,
  output logic       neg,
  output logic       ovf
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic [3:0] res_f;

`ifdef ALU_4BIT_FLAGS_EN
  logic [4:0] sum5;
  logic [4:0] diff5;
  logic       res_c;
  logic       res_v;

  // Combinational result plus carry/borrow and signed overflow; bit 4 of the
  // 5-bit difference is set exactly when a < b unsigned, i.e. the borrow.
  always_comb begin
    sum5  = {1'b0, a} + {1'b0, b};
    diff5 = {1'b0, a} - {1'b0, b};
    res_f = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op)
      OP_ADD: begin
        res_f = sum5[3:0];
        res_c = sum5[4];
        res_v = (a[3] == b[3]) && (sum5[3] != a[3]);
      end
      OP_SUB: begin
        res_f = diff5[3:0];
        res_c = diff5[4];
        res_v = (a[3] != b[3]) && (diff5[3] != a[3]);
      end
      OP_AND:  res_f = a & b;
      OP_OR:   res_f = a | b;
      default: res_f = '0;
    endcase
  end

  // Flag registers; reset reflects f=0, so zero comes up set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
      zero  <= 1'b1;
      neg   <= 1'b0;
      ovf   <= 1'b0;
    end else if (in_valid) begin
      carry <= res_c;
      zero  <= (res_f == 4'h0);
      neg   <= res_f[3];
      ovf   <= res_v;
    end
  end
`else
  // Combinational result only; flags are not built in this configuration.
  always_comb begin
    res_f = '0;
    case (op)
      OP_ADD:  res_f = a + b;
      OP_SUB:  res_f = a - b;
      OP_AND:  res_f = a & b;
      OP_OR:   res_f = a | b;
      default: res_f = '0;
    endcase
  end

  assign carry = 1'b0;
  assign zero  = 1'b0;
  assign neg   = 1'b0;
  assign ovf   = 1'b0;
`endif

  // Result register: captures only on accepted operations, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f <= 4'h0;
    end else if (in_valid) begin
      f <= res_f;
    end
  end

  // Valid pipeline: mirrors in_valid one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_alu_4_bit.sv
// Bench for alu_4_bit: vector table driven through a result queue, plus
// hold, reset-at-start and asynchronous mid-stream reset sequences.
// Flag expectations collapse to 0 when ALU_4BIT_FLAGS_EN is not defined.
module tb_alu_4_bit;

`ifdef ALU_4BIT_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] op;
  logic       out_valid;
  logic [3:0] f;
  logic       carry;
  logic       zero;
  logic       neg;
  logic       ovf;

  typedef struct packed {
    logic [3:0] f;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
  } res_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    res_t       r;
  } vec_t;

  res_t sb[$];
  res_t held;
  res_t rst_res;
  bit   exp_vld;
  int   total;
  int   bad;
  vec_t tbl[14];

  alu_4_bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .f         (f),
    .carry     (carry),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t mask(input res_t r);
    res_t m;
    m   = r;
    m.c = r.c & FL;
    m.z = r.z & FL;
    m.n = r.n & FL;
    m.v = r.v & FL;
    return m;
  endfunction

  // Compare outputs against the oldest queued result (or the held value when idle).
  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, int'(out_valid), int'(exp_vld));
    if (exp_vld) begin
      if (sb.size() == 0) begin
        chk({tag, ".queue_empty"}, 1, 0);
      end else begin
        held = sb.pop_front();
      end
    end
    chk({tag, ".f"},     int'(f),     int'(held.f));
    chk({tag, ".carry"}, int'(carry), int'(held.c));
    chk({tag, ".zero"},  int'(zero),  int'(held.z));
    chk({tag, ".neg"},   int'(neg),   int'(held.n));
    chk({tag, ".ovf"},   int'(ovf),   int'(held.v));
  endtask

  // One cycle: check the previous edge's outputs at negedge, then drive new inputs.
  task automatic step(input string tag, input bit vld, input logic [3:0] aa,
                      input logic [3:0] bb, input logic [1:0] oo, input res_t e);
    @(negedge clk);
    check_outputs(tag);
    in_valid = vld;
    a        = aa;
    b        = bb;
    op       = oo;
    if (vld) sb.push_back(mask(e));
    exp_vld = vld;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_res = mask('{f: 4'h0, c: 1'b0, z: 1'b1, n: 1'b0, v: 1'b0});
    held    = rst_res;
    exp_vld = 1'b0;

    //           a     b     op     f     c     z     n     v
    tbl[0]  = '{4'h2, 4'h6, 2'b00, '{4'h8, 1'b0, 1'b0, 1'b1, 1'b1}};
    tbl[1]  = '{4'h2, 4'h1, 2'b01, '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[2]  = '{4'h2, 4'h6, 2'b10, '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[3]  = '{4'h2, 4'h6, 2'b11, '{4'h6, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[4]  = '{4'hF, 4'h1, 2'b00, '{4'h0, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[5]  = '{4'h7, 4'h1, 2'b00, '{4'h8, 1'b0, 1'b0, 1'b1, 1'b1}};
    tbl[6]  = '{4'h2, 4'h6, 2'b01, '{4'hC, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[7]  = '{4'h8, 4'h1, 2'b01, '{4'h7, 1'b0, 1'b0, 1'b0, 1'b1}};
    tbl[8]  = '{4'h5, 4'h5, 2'b01, '{4'h0, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[9]  = '{4'h9, 4'h6, 2'b10, '{4'h0, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[10] = '{4'h8, 4'h8, 2'b00, '{4'h0, 1'b1, 1'b1, 1'b0, 1'b1}};
    tbl[11] = '{4'h0, 4'h1, 2'b01, '{4'hF, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[12] = '{4'h7, 4'hF, 2'b01, '{4'h8, 1'b1, 1'b0, 1'b1, 1'b1}};
    tbl[13] = '{4'hA, 4'h5, 2'b11, '{4'hF, 1'b0, 1'b0, 1'b1, 1'b0}};

    // Reset with no clock edge yet; valid operands present must not leak through.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 4'h2;
    b        = 4'h6;
    op       = 2'b00;
    #2;
    check_outputs("reset");
    in_valid = 1'b0;
    #1;
    rst_n = 1'b1;

    // Idle after release: outputs stay at reset values.
    step("idle0", 1'b0, 4'h0, 4'h0, 2'b00, '0);
    step("idle1", 1'b0, 4'h0, 4'h0, 2'b00, '0);

    // Back-to-back table vectors.
    for (int i = 0; i < 14; i++) begin
      step($sformatf("vec%0d", i), 1'b1, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].r);
    end

    // Hold: one ADD, then idle cycles keep f=7 with out_valid low.
    step("vec13_out", 1'b1, 4'h3, 4'h4, 2'b00, '{4'h7, 1'b0, 1'b0, 1'b0, 1'b0});
    step("hold_res", 1'b0, 4'h0, 4'h0, 2'b00, '0);
    step("hold1",    1'b0, 4'hF, 4'hF, 2'b01, '0);
    step("hold2",    1'b0, 4'h1, 4'h2, 2'b11, '0);
    step("hold3",    1'b0, 4'h0, 4'h0, 2'b00, '0);

    // Asynchronous reset in the middle of back-to-back operations.
    step("mid_a", 1'b1, 4'hF, 4'hF, 2'b00, '{4'hE, 1'b1, 1'b0, 1'b1, 1'b0});
    step("mid_b", 1'b1, 4'h9, 4'h3, 2'b11, '{4'hB, 1'b0, 1'b0, 1'b1, 1'b0});
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    exp_vld = 1'b0;
    held    = rst_res;
    check_outputs("mid_rst");
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check_outputs("mid_rst_hold");
    rst_n = 1'b1;
    step("post_rst_idle", 1'b1, 4'h7, 4'h1, 2'b00, '{4'h8, 1'b0, 1'b0, 1'b1, 1'b1});
    step("post_rst_op",   1'b0, 4'h0, 4'h0, 2'b00, '0);
    step("post_rst_hold", 1'b0, 4'h0, 4'h0, 2'b00, '0);

    chk("queue_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
